// File: rtl/et_err_pkg.sv
// Shared constants, FSM state type and the fixed test pattern for the ET-crate error serialiser.
package et_err_pkg;

    localparam int LENGTH_ET_TLK_ERR = 232;
    localparam int LENGTH_ET_DC_ERR  = 232;
    localparam int HDR_W             = 3;
    localparam int PAY_W = (LENGTH_ET_TLK_ERR > LENGTH_ET_DC_ERR) ? LENGTH_ET_TLK_ERR
                                                                  : LENGTH_ET_DC_ERR;

    localparam logic [HDR_W-1:0] HDR_TLK = 3'b100;
    localparam logic [HDR_W-1:0] HDR_DC  = 3'b101;

    typedef enum logic [3:0] {
        IDLE,
        GAP0,
        TLK_HDR,
        TLK_DATA,
        GAP1,
        DC_HDR,
        DC_DATA,
        GAP2,
        DONE
    } state_e;

    // One marker at the end of each 21-bit link group: bits 20, 41, ..., 230.
    function automatic logic [PAY_W-1:0] gen_testpat();
        logic [PAY_W-1:0] p;
        p = '0;
        for (int k = 0; k < PAY_W; k++) begin
            p[k] = (k % 21 == 20);
        end
        return p;
    endfunction

    localparam logic [PAY_W-1:0] TESTPAT = gen_testpat();

endpackage

// File: rtl/et_tx_err_encoder_if.sv
// Status/handshake bundle between the spill controller and the error serialiser.
// in_testpat exists only when ET_TX_ERR_TESTPAT_EN is defined.
interface et_tx_err_encoder_if;
    import et_err_pkg::*;

    logic                         in_live;
    logic                         in_start;
    logic [LENGTH_ET_TLK_ERR-1:0] in_tlk_err;
    logic [LENGTH_ET_DC_ERR-1:0]  in_dc_err;
`ifdef ET_TX_ERR_TESTPAT_EN
    logic                         in_testpat;
`endif
    logic                         out_err;
    logic                         out_busy;
    logic                         out_done;

    modport master (
        output in_live, in_start, in_tlk_err, in_dc_err,
`ifdef ET_TX_ERR_TESTPAT_EN
        output in_testpat,
`endif
        input  out_err, out_busy, out_done
    );

    modport slave (
        input  in_live, in_start, in_tlk_err, in_dc_err,
`ifdef ET_TX_ERR_TESTPAT_EN
        input  in_testpat,
`endif
        output out_err, out_busy, out_done
    );

endinterface

// File: rtl/et_err_frame_ser.sv
// Header+payload shift register: header bit2 first, then payload bit0 upward.
// A sentinel one above the payload flags the final bit without a counter.
module et_err_frame_ser
    import et_err_pkg::*;
#(
    parameter int PW = PAY_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [HDR_W-1:0] header,
    input  logic [PW-1:0]    payload,
    output logic             bit_out,
    output logic             last
);

    localparam int SW = HDR_W + PW + 1;

    logic [SW-1:0] sh;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh <= '0;
        end else if (load) begin
            sh <= {1'b1, payload, header[0], header[1], header[2]};
        end else if (shift) begin
            sh <= {1'b0, sh[SW-1:1]};
        end
    end

    assign bit_out = sh[0];
    assign last    = (sh[SW-1:1] == (SW-1)'(1));

endmodule

// File: rtl/et_tx_err_encoder.sv
// ET-crate per-spill error serialiser: gap, TLK frame, gap, DC frame, gap, done pulse.
// Optional feature macro: ET_TX_ERR_TESTPAT_EN (adds in_testpat to load a fixed pattern).
module et_tx_err_encoder
    import et_err_pkg::*;
#(
    parameter int GAP_CYCLES = 4
) (
    input logic                clk,
    input logic                rst,
    et_tx_err_encoder_if.slave bus
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [7:0] HDR_LAST = 8'(HDR_W - 1);
    localparam logic [7:0] TLK_LAST = 8'(LENGTH_ET_TLK_ERR - 1);
    localparam logic [7:0] DC_LAST  = 8'(LENGTH_ET_DC_ERR - 1);

    state_e                       state, state_next;
    logic [7:0]                   cnt, cnt_next;
    logic [LENGTH_ET_TLK_ERR-1:0] tlk_snap;
    logic [LENGTH_ET_DC_ERR-1:0]  dc_snap;
    logic                         capture;
    logic                         use_pat;
    logic                         ser_load, ser_shift;
    logic [HDR_W-1:0]             ser_hdr;
    logic [PAY_W-1:0]             ser_pay;
    logic                         ser_bit, ser_last;
    logic                         tx_phase;

`ifdef ET_TX_ERR_TESTPAT_EN
    assign use_pat = bus.in_testpat;
`else
    assign use_pat = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        ser_load   = 1'b0;
        ser_shift  = 1'b0;
        ser_hdr    = HDR_TLK;
        ser_pay    = PAY_W'(tlk_snap);

        unique case (state)
            IDLE: begin
                if (bus.in_start && bus.in_live) begin
                    state_next = GAP0;
                    capture    = 1'b1;
                end
            end
            GAP0: begin
                if (cnt == GAP_LAST) begin
                    state_next = TLK_HDR;
                    ser_load   = 1'b1;
                end
            end
            TLK_HDR: begin
                ser_shift = 1'b1;
                if (cnt == HDR_LAST) state_next = TLK_DATA;
            end
            TLK_DATA: begin
                ser_shift = 1'b1;
                if (cnt == TLK_LAST) state_next = GAP1;
            end
            GAP1: begin
                ser_hdr = HDR_DC;
                ser_pay = PAY_W'(dc_snap);
                if (cnt == GAP_LAST) begin
                    state_next = DC_HDR;
                    ser_load   = 1'b1;
                end
            end
            DC_HDR: begin
                ser_shift = 1'b1;
                if (cnt == HDR_LAST) state_next = DC_DATA;
            end
            DC_DATA: begin
                ser_shift = 1'b1;
                if (cnt == DC_LAST) state_next = GAP2;
            end
            GAP2: begin
                if (cnt == GAP_LAST) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Losing the link abandons the spill outright; nothing is resumed later.
        if (state != IDLE && !bus.in_live) begin
            state_next = IDLE;
            ser_load   = 1'b0;
            ser_shift  = 1'b0;
        end

        cnt_next = (state_next != state || state == IDLE) ? 8'd0 : cnt + 8'd1;
    end

    // NOTE: the wide snapshots are plain registers, so clearing them on reset is cheap and keeps state defined.
    always_ff @(posedge clk) begin
        if (rst) begin
            tlk_snap <= '0;
            dc_snap  <= '0;
        end else if (capture) begin
            tlk_snap <= use_pat ? TESTPAT[LENGTH_ET_TLK_ERR-1:0] : bus.in_tlk_err;
            dc_snap  <= use_pat ? TESTPAT[LENGTH_ET_DC_ERR-1:0]  : bus.in_dc_err;
        end
    end

    et_err_frame_ser #(.PW(PAY_W)) u_ser (
        .clk     (clk),
        .rst     (rst),
        .load    (ser_load),
        .shift   (ser_shift),
        .header  (ser_hdr),
        .payload (ser_pay),
        .bit_out (ser_bit),
        .last    (ser_last)
    );

    // The bit counter and the serialiser sentinel must agree on the final payload bit.
    always_ff @(posedge clk) begin
        if (!rst && ((state == TLK_DATA && cnt == TLK_LAST) ||
                     (state == DC_DATA  && cnt == DC_LAST))) begin
            assert (ser_last);
        end
    end

    assign tx_phase     = (state == TLK_HDR) || (state == TLK_DATA) ||
                          (state == DC_HDR)  || (state == DC_DATA);
    assign bus.out_err  = tx_phase & ser_bit;
    assign bus.out_busy = (state != IDLE) && (state != DONE);
    assign bus.out_done = (state == DONE);

endmodule

// File: tb/tb_et_tx_err_encoder.sv
// Scoreboard bench for et_tx_err_encoder: driver queues expected spills, a monitor decodes out_err.
module tb_et_tx_err_encoder;

    localparam int L          = 232;
    localparam int GAP        = 4;
    localparam int FRAME_BITS = 3 * GAP + 6 + 2 * L;

    typedef struct {
        int           start_cyc;
        int           len;
        bit           done;
        logic [L-1:0] tlk;
        logic [L-1:0] dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   idle_bad = 0;

    exp_t exp_q[$];
    logic obs[$];
    bit   collecting = 1'b0;
    int   first_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    et_tx_err_encoder_if bus ();

    et_tx_err_encoder #(.GAP_CYCLES(GAP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, want);
    endtask

    function automatic logic [L-1:0] testpat();
        logic [L-1:0] p;
        for (int k = 0; k < L; k++) p[k] = (k % 21 == 20);
        return p;
    endfunction

    function automatic logic [L-1:0] rand_vec();
        logic [L-1:0] v;
        for (int k = 0; k < L; k++) v[k] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    // Expected line level at busy cycle i (0-based) of a complete spill.
    function automatic logic exp_bit(input exp_t e, input int i);
        logic [2:0] h_t;
        logic [2:0] h_d;
        int p;
        h_t = 3'b100;
        h_d = 3'b101;
        p = i;
        if (p < GAP) return 1'b0;
        p -= GAP;
        if (p < 3) return h_t[2-p];
        p -= 3;
        if (p < L) return e.tlk[p];
        p -= L;
        if (p < GAP) return 1'b0;
        p -= GAP;
        if (p < 3) return h_d[2-p];
        p -= 3;
        if (p < L) return e.dc[p];
        return 1'b0;
    endfunction

    task automatic finalize(input logic done_now, input logic err_now);
        exp_t e;
        logic [L-1:0] wt, wd;
        logic [2:0] ht, hd;
        int bad, lim;
        if (err_now) idle_bad++;
        check("expected_frame_pending", exp_q.size() > 0, 1'b1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("start_latency", first_cyc, e.start_cyc);
        check("busy_cycles", obs.size(), e.len);
        check("done_pulse", done_now, e.done);
        bad = 0;
        lim = (obs.size() < e.len) ? obs.size() : e.len;
        for (int i = 0; i < lim; i++) begin
            if (obs[i] !== exp_bit(e, i)) bad++;
        end
        check("stream_bit_errors", bad, 0);
        if (e.done && obs.size() == FRAME_BITS) begin
            ht = {obs[GAP], obs[GAP+1], obs[GAP+2]};
            hd = {obs[2*GAP+3+L], obs[2*GAP+4+L], obs[2*GAP+5+L]};
            for (int k = 0; k < L; k++) begin
                wt[k] = obs[GAP+3+k];
                wd[k] = obs[2*GAP+6+L+k];
            end
            check("tlk_header", ht, 3'b100);
            check("tlk_word", wt, e.tlk);
            check("dc_header", hd, 3'b101);
            check("dc_word", wd, e.dc);
        end
    endtask

    always @(negedge clk) begin
        if (bus.out_busy === 1'b1) begin
            if (!collecting) begin
                collecting = 1'b1;
                first_cyc  = cyc;
                obs.delete();
            end
            obs.push_back(bus.out_err);
        end else if (collecting) begin
            collecting = 1'b0;
            finalize(bus.out_done, bus.out_err);
        end else if (bus.out_err === 1'b1 || bus.out_done === 1'b1) begin
            idle_bad++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int c, input logic [L-1:0] t, input logic [L-1:0] d, input bit pat);
        exp_t e;
        e.start_cyc = c + 1;
        e.len       = FRAME_BITS;
        e.done      = 1'b1;
        e.tlk       = pat ? testpat() : t;
        e.dc        = pat ? testpat() : d;
        exp_q.push_back(e);
    endtask

    task automatic start_frame(input logic [L-1:0] t, input logic [L-1:0] d, input bit pat,
                               output int c);
        bus.in_tlk_err = t;
        bus.in_dc_err  = d;
`ifdef ET_TX_ERR_TESTPAT_EN
        bus.in_testpat = pat;
`endif
        bus.in_start = 1'b1;
        c = cyc;
        push_exp(c, t, d, pat);
        tick();
        bus.in_start   = 1'b0;
        bus.in_tlk_err = rand_vec();
        bus.in_dc_err  = rand_vec();
`ifdef ET_TX_ERR_TESTPAT_EN
        bus.in_testpat = 1'b0;
`endif
    endtask

    task automatic wait_quiet(input int budget);
        int n;
        n = 0;
        while ((bus.out_busy || bus.out_done) && n < budget) begin
            tick();
            n++;
        end
        check("wait_quiet_in_budget", n < budget, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c, n;
        logic [L-1:0] one;
        bus.in_live    = 1'b1;
        bus.in_start   = 1'b0;
        bus.in_tlk_err = '0;
        bus.in_dc_err  = '0;
`ifdef ET_TX_ERR_TESTPAT_EN
        bus.in_testpat = 1'b0;
`endif
        tick();
        tick();
        check("reset_err", bus.out_err, 1'b0);
        check("reset_busy", bus.out_busy, 1'b0);
        check("reset_done", bus.out_done, 1'b0);
        rst = 1'b0;
        repeat (10) tick();
        check("idle_busy", bus.out_busy, 1'b0);
        check("idle_err", bus.out_err, 1'b0);

        // Single set bit in TLK word, DC word empty.
        one = '0;
        one[0] = 1'b1;
        start_frame(one, '0, 1'b0, c);
        wait_quiet(1000);

        // Random spills; the second also carries a start pulse mid-frame that must be ignored.
        for (int r = 0; r < 4; r++) begin
            start_frame(rand_vec(), rand_vec(), 1'b0, c);
            if (r == 1) begin
                while (cyc < c + 50) tick();
                bus.in_start = 1'b1;
                tick();
                bus.in_start = 1'b0;
            end
            wait_quiet(1000);
        end

        // Link loss at cycle 100 after start, plus a start offered while the link is down.
        start_frame(rand_vec(), rand_vec(), 1'b0, c);
        exp_q[exp_q.size()-1].len  = 100;
        exp_q[exp_q.size()-1].done = 1'b0;
        while (cyc < c + 100) tick();
        bus.in_live = 1'b0;
        tick();
        bus.in_start = 1'b1;
        tick();
        check("abort_busy_low", bus.out_busy, 1'b0);
        check("abort_err_low", bus.out_err, 1'b0);
        bus.in_start = 1'b0;
        bus.in_live  = 1'b1;
        wait_quiet(1000);
        start_frame(rand_vec(), rand_vec(), 1'b0, c);

        // Start held across the DONE cycle: ignored in DONE, accepted in the first IDLE cycle.
        n = 0;
        while (!bus.out_done && n < 1000) begin
            tick();
            n++;
        end
        check("reach_done", bus.out_done, 1'b1);
        bus.in_tlk_err = rand_vec();
        bus.in_dc_err  = rand_vec();
        bus.in_start   = 1'b1;
        tick();
        c = cyc;
        push_exp(c, bus.in_tlk_err, bus.in_dc_err, 1'b0);
        tick();
        bus.in_start   = 1'b0;
        bus.in_tlk_err = rand_vec();
        wait_quiet(1000);

        // Synchronous reset mid-frame truncates the spill.
        start_frame(rand_vec(), rand_vec(), 1'b0, c);
        exp_q[exp_q.size()-1].len  = 300;
        exp_q[exp_q.size()-1].done = 1'b0;
        while (cyc < c + 300) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_midframe_err", bus.out_err, 1'b0);
        wait_quiet(1000);
        start_frame(rand_vec(), rand_vec(), 1'b0, c);
        wait_quiet(1000);

`ifdef ET_TX_ERR_TESTPAT_EN
        start_frame(rand_vec(), rand_vec(), 1'b1, c);
        wait_quiet(1000);
`endif

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        check("idle_quiet_violations", idle_bad, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
